keccak_rc_gen: RTL and testbench

Iterative Keccak-f[1600] round-constant generator that feeds the iota stage. For a requested round index it computes the 64-bit constant RC[ir] using the FIPS 202 rc(t) LFSR, one LFSR step per cycle. It keeps the LFSR position across requests, so in-order rounds cost no seek time. Results are handed over on a valid/ready pair.

---
 rtl/keccak_pkg.sv | 30 +++
 rtl/keccak_rc_gen_if.sv | 31 +++
 rtl/keccak_rc_lfsr.sv | 27 ++
 rtl/keccak_rc_gen.sv | 121 ++++++++++++
 tb/tb_keccak_rc_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak-f[1600] round-constant generator.
package keccak_pkg;

   localparam int NUM_ROUNDS = 24;
   localparam int LANE_W     = 64;

   // Highest legal round index, as a 5-bit value comparable with req_round.
   localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

   // rc(t) LFSR: R[0] is the output bit, seed has only R[0] set.
   localparam logic [7:0] LFSR_SEED = 8'h01;
   // Feedback from R[7] is XORed into R[0], R[4], R[5], R[6].
   localparam logic [7:0] LFSR_TAPS = 8'b0111_0001;

   // Lane bit positions 2^j - 1 that receive rc(7*ir + j), j = 0..6.
   localparam logic [5:0] RC_POS [0:6] = '{6'd0, 6'd1, 6'd3, 6'd7, 6'd15, 6'd31, 6'd63};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEEK    = 2'd1,
      COLLECT = 2'd2,
      DONE    = 2'd3
   } state_t;

   // LFSR position of the first bit of round ir (7*ir; 7*31 = 217 fits 8 bits).
   function automatic logic [7:0] round_start(input logic [4:0] ir);
      return {3'b000, ir} * 8'd7;
   endfunction

endpackage

// File: rtl/keccak_rc_gen_if.sv
// Request/response bundle between a round-constant consumer and keccak_rc_gen.
//
// Handshake: a transfer happens on the rising edge where valid && ready are
// both high. A source holds valid and its payload stable until that edge; a
// sink may raise or drop ready freely. The generator holds one request at a
// time: req_ready is low from accept until after the response transfer.
interface keccak_rc_gen_if;
   import keccak_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [4:0]        req_round;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [LANE_W-1:0] rsp_rc;
   logic [4:0]        rsp_round;
   logic              rsp_err;

   // Consumer side: issues rounds, accepts constants.
   modport master (
      output req_valid, req_round, rsp_ready,
      input  req_ready, rsp_valid, rsp_rc, rsp_round, rsp_err
   );

   // Generator side.
   modport slave (
      input  req_valid, req_round, rsp_ready,
      output req_ready, rsp_valid, rsp_rc, rsp_round, rsp_err
   );

endinterface

// File: rtl/keccak_rc_lfsr.sv
// 8-bit FIPS 202 rc(t) LFSR; out is rc(t) for the current position t.
module keccak_rc_lfsr
   import keccak_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic load_seed,
   input  logic step,
   output logic out
);

   logic [7:0] r;

   // Shift toward higher index, fold R[7] back into the tap positions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r <= LFSR_SEED;
      end else if (load_seed) begin
         r <= LFSR_SEED;
      end else if (step) begin
         r <= {r[6:0], 1'b0} ^ (LFSR_TAPS & {8{r[7]}});
      end
   end

   assign out = r[0];

endmodule

// File: rtl/keccak_rc_gen.sv
// Iterative Keccak round-constant generator. The LFSR position is kept
// across requests so in-order rounds start collecting with no seek.
module keccak_rc_gen
   import keccak_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   keccak_rc_gen_if.slave  bus,
   output state_t          dbg_state
);

   state_t            state;
   logic [7:0]        t;        // LFSR steps taken since the seed
   logic [7:0]        target;   // 7*ir of the request in flight
   logic [2:0]        j;        // collect bit index
   logic [LANE_W-1:0] rc_q;
   logic [4:0]        round_q;
   logic              err_q;
   logic              rdy_q;
   logic              vld_q;

   logic              accept;
   logic              legal;
   logic              rewind;
   logic              lfsr_load;
   logic              lfsr_step;
   logic              lfsr_out;

   // Request decode and LFSR control for the current state.
   always_comb begin
      accept    = 1'b0;
      legal     = 1'b0;
      rewind    = 1'b0;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      accept = (state == IDLE) && bus.req_valid;
      legal  = (bus.req_round <= LAST_ROUND);
      rewind = (round_start(bus.req_round) < t);
      lfsr_load = accept && legal && rewind;
      lfsr_step = ((state == SEEK) && (t != target)) || (state == COLLECT);
   end

   keccak_rc_lfsr u_lfsr (
      .clk       (clk),
      .reset     (reset),
      .load_seed (lfsr_load),
      .step      (lfsr_step),
      .out       (lfsr_out)
   );

   // Control FSM with position counter and registered response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         t       <= 8'd0;
         target  <= 8'd0;
         j       <= 3'd0;
         rc_q    <= '0;
         round_q <= 5'd0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b1;
         vld_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  round_q <= bus.req_round;
                  rc_q    <= '0;
                  rdy_q   <= 1'b0;
                  target  <= round_start(bus.req_round);
                  j       <= 3'd0;
                  if (!legal) begin
                     // Illegal rounds leave the LFSR position alone.
                     err_q <= 1'b1;
                     vld_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     err_q <= 1'b0;
                     if (rewind) begin
                        t <= 8'd0;
                     end
                     state <= SEEK;
                  end
               end
            end
            SEEK: begin
               if (t == target) begin
                  state <= COLLECT;
               end else begin
                  t <= t + 8'd1;
               end
            end
            COLLECT: begin
               rc_q[RC_POS[j]] <= lfsr_out;
               t <= t + 8'd1;
               j <= j + 3'd1;
               if (j == 3'd6) begin
                  vld_q <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  vld_q <= 1'b0;
                  rdy_q <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = rdy_q;
   assign bus.rsp_valid = vld_q;
   assign bus.rsp_rc    = rc_q;
   assign bus.rsp_round = round_q;
   assign bus.rsp_err   = err_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_keccak_rc_gen.sv
// Directed bench for keccak_rc_gen: vector table plus stall and reset sequences.
module tb_keccak_rc_gen;
   import keccak_pkg::*;

   logic   clk;
   logic   reset;
   state_t dbg_state;

   keccak_rc_gen_if bus ();

   keccak_rc_gen dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      bit          do_reset;
      logic [4:0]  round;
      logic [63:0] rc;
      bit          err;
      int          cyc;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   // Issue one request; returns the cycle (accept edge = 0) where rsp_valid is seen.
   task automatic do_req(input logic [4:0] round, output int cyc);
      check("req_ready_before_req", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_round = round;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      cyc = 1;
      if (!bus.rsp_valid) check("req_ready_busy", 64'(bus.req_ready), 64'd0);
      while (!bus.rsp_valid && cyc < 400) begin
         @(posedge clk);
         #1 cyc++;
      end
      if (!bus.rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_handshake();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      check("req_ready_after_hs", 64'(bus.req_ready), 64'd1);
      check("rsp_valid_after_hs", 64'(bus.rsp_valid), 64'd0);
   endtask

   // Compare the response against the scoreboard entry pushed at request time.
   task automatic score_rsp(input string name);
      logic [63:0] exp_rc;
      if (exp_q.size() == 0) begin
         check({name, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         exp_rc = exp_q.pop_front();
         check({name, "_rc"}, bus.rsp_rc, exp_rc);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_req_ready"}, 64'(bus.req_ready), 64'd1);
      check({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
      check({name, "_rsp_rc"},    bus.rsp_rc,          64'd0);
      check({name, "_rsp_round"}, 64'(bus.rsp_round), 64'd0);
      check({name, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
      check({name, "_state"},     64'(dbg_state),     64'(IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          cyc;
      logic [63:0] held;
      int          guard;

      vecs[0] = '{1'b1, 5'd0,  64'h0000000000000001, 1'b0, 9};
      vecs[1] = '{1'b0, 5'd1,  64'h0000000000008082, 1'b0, 9};
      vecs[2] = '{1'b0, 5'd2,  64'h800000000000808A, 1'b0, 9};
      vecs[3] = '{1'b0, 5'd3,  64'h8000000080008000, 1'b0, 9};
      vecs[4] = '{1'b1, 5'd23, 64'h8000000080008008, 1'b0, 170};
      vecs[5] = '{1'b0, 5'd5,  64'h0000000080000001, 1'b0, 44};   // rewind, S=35
      vecs[6] = '{1'b0, 5'd24, 64'h0000000000000000, 1'b1, 1};
      vecs[7] = '{1'b0, 5'd0,  64'h0000000000000001, 1'b0, 9};    // rewind, S=0
      vecs[8] = '{1'b0, 5'd4,  64'h000000000000808B, 1'b0, 30};   // t=7 -> 28
      vecs[9] = '{1'b0, 5'd31, 64'h0000000000000000, 1'b1, 1};

      bus.req_valid = 1'b0;
      bus.req_round = 5'd0;
      bus.rsp_ready = 1'b0;
      reset = 1'b1;
      #2;
      check_reset_outputs("reset_async");
      apply_reset();
      check_reset_outputs("reset");

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].do_reset) apply_reset();
         exp_q.push_back(vecs[i].rc);
         do_req(vecs[i].round, cyc);
         score_rsp($sformatf("vec%0d", i));
         check($sformatf("vec%0d_err", i),   64'(bus.rsp_err),   64'(vecs[i].err));
         check($sformatf("vec%0d_round", i), 64'(bus.rsp_round), 64'(vecs[i].round));
         check($sformatf("vec%0d_cyc", i),   64'(cyc),           64'(vecs[i].cyc));
         do_handshake();
      end

      // Stall: round 1 after the illegal 31 (t=35 -> rewind), hold rsp_ready low.
      exp_q.push_back(64'h0000000000008082);
      do_req(5'd1, cyc);
      check("stall_cyc", 64'(cyc), 64'd16);
      held = bus.rsp_rc;
      score_rsp("stall");
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_rc !== held || !bus.rsp_valid || bus.req_ready) begin
            check($sformatf("stall_hold_%0d", k), {bus.rsp_rc[61:0], bus.rsp_valid, bus.req_ready},
                  {held[61:0], 1'b1, 1'b0});
         end else begin
            n_checks++;
         end
      end
      check("stall_rc_end", bus.rsp_rc, 64'h0000000000008082);
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
      do_handshake();

      // Reset during COLLECT of round 10 (t=14 -> S=56).
      bus.req_valid = 1'b1;
      bus.req_round = 5'd10;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      guard = 0;
      while (dbg_state != COLLECT && guard < 200) begin
         @(posedge clk);
         #1 guard++;
      end
      check("reach_collect", 64'(dbg_state), 64'(COLLECT));
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("mid_collect_reset");
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) check("no_stale_valid", 64'(bus.rsp_valid), 64'd0);
      end
      check("post_reset_idle", 64'(dbg_state), 64'(IDLE));
      exp_q.push_back(64'h0000000080008009);
      do_req(5'd10, cyc);
      score_rsp("round10");
      check("round10_cyc", 64'(cyc), 64'd79);
      check("round10_err", 64'(bus.rsp_err), 64'd0);
      do_handshake();

      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "time limit");
   end

endmodule
